// File: rtl/note_sequencer.sv
// note_sequencer: plays a melody held in a small writable note RAM by driving
// the one-hot tone-select bus of the audio generator. Any non-zero live_keys
// input takes priority over the sequenced tone.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   ena        sample-rate enable; beat and gap timing count these ticks
//   start      one-cycle pulse; (re)starts playback at address 0
//   stop       one-cycle pulse; aborts playback (wins over start)
//   loop       level; restart at address 0 on end-of-song
//   live_keys  live switch tones, passed through unmodified when non-zero
//   wr_en      note RAM write strobe
//   wr_addr    note RAM write address
//   wr_data    entry: [7] end marker, [6] rest, [5:3] note index, [2:0] beats-1
//   sw_tones   registered one-hot tone select
//   busy       high in every state except IDLE
//   done       one-cycle pulse at a non-looping end of song
//   cur_addr   address of the entry currently playing
module note_sequencer #(
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned TICKS_PER_BEAT = 10425,
    parameter int unsigned GAP_TICKS      = 417
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [7:0]        live_keys,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        sw_tones,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned TICK_W = $clog2(TICKS_PER_BEAT);

    localparam logic [TICK_W-1:0] BEAT_LAST = TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [TICK_W-1:0] NOTE_LAST = TICK_W'(TICKS_PER_BEAT - GAP_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_NOTE,
        S_GAP
    } state_t;

    state_t              state, state_nxt;
    logic [TICK_W-1:0]   tick, tick_nxt;
    logic [2:0]          beat, beat_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                done_nxt;
    logic [7:0]          mem [DEPTH];
    logic [7:0]          rd_data;
    logic [2:0]          note_idx;
    logic                note_rest;
    logic [7:0]          seq_tone;

    // Note RAM: not reset; a read issued in FETCH sees the pre-write contents
    // if the same address is written in that cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (state == S_FETCH) begin
            rd_data <= mem[cur_addr];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            tick      <= '0;
            beat      <= '0;
            cur_addr  <= '0;
            done      <= 1'b0;
            note_idx  <= '0;
            note_rest <= 1'b0;
            sw_tones  <= '0;
        end else begin
            state    <= state_nxt;
            tick     <= tick_nxt;
            beat     <= beat_nxt;
            cur_addr <= addr_nxt;
            done     <= done_nxt;
            if (state == S_DECODE) begin
                note_idx  <= rd_data[5:3];
                note_rest <= rd_data[6];
            end
            sw_tones <= (live_keys != '0) ? live_keys : seq_tone;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        beat_nxt  = beat;
        addr_nxt  = cur_addr;
        done_nxt  = 1'b0;
        if (stop) begin
            state_nxt = S_IDLE;
            tick_nxt  = '0;
            beat_nxt  = '0;
        end else if (start) begin
            state_nxt = S_FETCH;
            addr_nxt  = '0;
            tick_nxt  = '0;
            beat_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: ;
                S_FETCH: state_nxt = S_DECODE;
                S_DECODE: begin
                    if (rd_data[7]) begin
                        if (loop) begin
                            addr_nxt  = '0;
                            state_nxt = S_FETCH;
                        end else begin
                            done_nxt  = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        beat_nxt  = rd_data[2:0];
                        tick_nxt  = '0;
                        state_nxt = S_NOTE;
                    end
                end
                S_NOTE: begin
                    if (ena) begin
                        // The final beat is cut short so that the trailing
                        // gap fits inside the note's nominal length.
                        if (beat == '0 && tick == NOTE_LAST) begin
                            tick_nxt  = '0;
                            state_nxt = S_GAP;
                        end else if (tick == BEAT_LAST) begin
                            tick_nxt = '0;
                            beat_nxt = beat - 3'd1;
                        end else begin
                            tick_nxt = tick + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (ena) begin
                        if (tick == GAP_LAST) begin
                            tick_nxt = '0;
                            if (cur_addr == '1) begin
                                // Running off the end of the RAM is an implicit end marker.
                                addr_nxt = '0;
                                if (loop) begin
                                    state_nxt = S_FETCH;
                                end else begin
                                    done_nxt  = 1'b1;
                                    state_nxt = S_IDLE;
                                end
                            end else begin
                                addr_nxt  = cur_addr + 1'b1;
                                state_nxt = S_FETCH;
                            end
                        end else begin
                            tick_nxt = tick + 1'b1;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        busy     = (state != S_IDLE);
        seq_tone = '0;
        if (state == S_NOTE && !note_rest) begin
            seq_tone = 8'b1 << note_idx;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

    logic       clk;
    logic       reset;
    logic       ena;
    logic       start;
    logic       stop;
    logic       loop;
    logic [7:0] live_keys;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] sw_tones;
    logic       busy;
    logic       done;
    logic [3:0] cur_addr;

    int vectors     = 0;
    int miscompares = 0;

    note_sequencer #(
        .ADDR_W(4),
        .TICKS_PER_BEAT(8),
        .GAP_TICKS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ena(ena),
        .start(start),
        .stop(stop),
        .loop(loop),
        .live_keys(live_keys),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .sw_tones(sw_tones),
        .busy(busy),
        .done(done),
        .cur_addr(cur_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [7:0] onehot(input int i);
        return 8'(1) << i;
    endfunction

    initial begin
        reset = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        live_keys = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #12;
        chk("rst_sw", sw_tones, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_done", {7'd0, done}, 8'h00);
        chk("rst_addr", {4'd0, cur_addr}, 8'h00);
        reset = 1'b1;
        step();

        // Single 2-beat Do5 then end marker, no loop.
        wr(4'd0, 8'h01);
        wr(4'd1, 8'h80);
        pulse_start();
        chk("t1_busy0", {7'd0, busy}, 8'h01);
        for (int k = 1; k <= 22; k++) begin
            step();
            chk($sformatf("t1_sw_k%0d", k), sw_tones, (k >= 3 && k <= 16) ? 8'h01 : 8'h00);
            chk($sformatf("t1_done_k%0d", k), {7'd0, done}, {7'd0, k == 20});
            chk($sformatf("t1_busy_k%0d", k), {7'd0, busy}, {7'd0, k < 20});
        end

        // Live-key override mid-note; note still ends on its schedule.
        pulse_start();
        for (int k = 1; k <= 22; k++) begin
            step();
            chk($sformatf("ov_sw_k%0d", k), sw_tones,
                (k >= 6 && k <= 8) ? 8'h04 : ((k >= 3 && k <= 16) ? 8'h01 : 8'h00));
            chk($sformatf("ov_done_k%0d", k), {7'd0, done}, {7'd0, k == 20});
            if (k == 5) live_keys = 8'h04;
            if (k == 8) live_keys = 8'h00;
        end
        live_keys = 8'h81;
        step();
        chk("multihot_sw", sw_tones, 8'h81);
        chk("multihot_busy", {7'd0, busy}, 8'h00);
        live_keys = 8'h00;
        step();
        chk("multihot_rel", sw_tones, 8'h00);

        // ena one cycle in four.
        ena = 1'b0;
        pulse_start();
        for (int k = 1; k <= 70; k++) begin
            step();
            chk($sformatf("ena4_sw_k%0d", k), sw_tones, (k >= 3 && k <= 56) ? 8'h01 : 8'h00);
            chk($sformatf("ena4_done_k%0d", k), {7'd0, done}, {7'd0, k == 66});
            chk($sformatf("ena4_busy_k%0d", k), {7'd0, busy}, {7'd0, k < 66});
            ena = ((k + 1) % 4 == 0);
        end
        ena = 1'b1;

        // Looping rest / index 7 / end; then stop mid-note.
        wr(4'd0, 8'h48);
        wr(4'd1, 8'h38);
        wr(4'd2, 8'h80);
        loop = 1'b1;
        pulse_start();
        for (int k = 1; k <= 59; k++) begin
            step();
            chk($sformatf("lp_sw_k%0d", k), sw_tones,
                (k >= 13 && ((k - 13) % 22) <= 5) ? 8'h80 : 8'h00);
            chk($sformatf("lp_addr_k%0d", k), {4'd0, cur_addr},
                ((k % 22) < 10) ? 8'd0 : (((k % 22) < 20) ? 8'd1 : 8'd2));
            chk($sformatf("lp_done_k%0d", k), {7'd0, done}, 8'h00);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", {7'd0, busy}, 8'h00);
        chk("stop_sw_lag", sw_tones, 8'h80);
        chk("stop_done", {7'd0, done}, 8'h00);
        step();
        chk("stop_sw", sw_tones, 8'h00);
        chk("stop_done2", {7'd0, done}, 8'h00);
        loop = 1'b0;

        // start and stop together: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", {7'd0, busy}, 8'h00);

        // All 16 entries, no end marker; rewrite RAM[3] while entry 2 plays.
        for (int i = 0; i < 16; i++) wr(4'(i), 8'((i % 8) << 3));
        pulse_start();
        for (int k = 1; k <= 162; k++) begin
            step();
            chk($sformatf("fill_sw_k%0d", k), sw_tones,
                (k < 160 && (k % 10) >= 3 && (k % 10) <= 8)
                    ? onehot((k / 10 == 3) ? 5 : (k / 10) % 8) : 8'h00);
            chk($sformatf("fill_addr_k%0d", k), {4'd0, cur_addr}, (k < 160) ? 8'(k / 10) : 8'd0);
            chk($sformatf("fill_done_k%0d", k), {7'd0, done}, {7'd0, k == 160});
            chk($sformatf("fill_busy_k%0d", k), {7'd0, busy}, {7'd0, k < 160});
            if (k == 23) begin
                wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h28;
            end
            if (k == 24) wr_en = 1'b0;
        end

        // start while busy restarts at address 0.
        pulse_start();
        for (int k = 1; k <= 35; k++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rs_addr", {4'd0, cur_addr}, 8'h00);
        chk("rs_busy", {7'd0, busy}, 8'h01);
        chk("rs_sw_lag", sw_tones, 8'h20);
        step();
        chk("rs_sw_fetch", sw_tones, 8'h00);
        step();
        step();
        step();
        chk("rs_sw_note0", sw_tones, 8'h01);
        for (int k = 0; k < 10; k++) step();
        chk("rs_sw_note1", sw_tones, 8'h02);
        chk("rs_addr1", {4'd0, cur_addr}, 8'h01);

        // Asynchronous reset mid-note, between clock edges.
        #2;
        reset = 1'b0;
        #1;
        chk("arst_sw", sw_tones, 8'h00);
        chk("arst_busy", {7'd0, busy}, 8'h00);
        chk("arst_done", {7'd0, done}, 8'h00);
        chk("arst_addr", {4'd0, cur_addr}, 8'h00);
        reset = 1'b1;
        step();
        chk("post_rst_busy", {7'd0, busy}, 8'h00);

        // RAM contents survive reset.
        pulse_start();
        step();
        step();
        step();
        chk("ram_kept_sw", sw_tones, 8'h01);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
